boot_ldr_ctr: RTL and testbench



---
 rtl/boot_ldr_pkg.sv | 24 ++
 rtl/sp_rom.sv | 24 ++
 rtl/boot_ldr_ctr.sv | 167 ++++++++++++++++
 tb/tb_boot_ldr_ctr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_ldr_pkg.sv
// Shared encodings for the boot loader controller: FSM states, CPU register map,
// control/status bit positions and the compiled-in boot ROM image.
package boot_ldr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_CSUM = 1'b1;

  localparam int BOOT_BIT   = 0;
  localparam int REBOOT_BIT = 1;
  localparam int IMGSEL_LSB = 2;
  localparam int BUSY_BIT   = 1;

  // Word a of the flat boot ROM; wider data paths see the upper half as well.
  function automatic logic [63:0] boot_word(input logic [31:0] a);
    return {a ^ 32'hB007_1DAD, 32'h1234_0000 + a * 32'h0000_0101};
  endfunction

endpackage

// File: rtl/sp_rom.sv
// Single-port boot ROM with one cycle read latency; output holds while r_en is low.
module sp_rom
  import boot_ldr_pkg::*;
#(
  parameter int    DATA_W = 32,
  parameter int    ADDR_W = 11,
  parameter string FILE   = ""
) (
  input  logic              clk,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata
);

  // No image name means an unprogrammed part, which reads back as all ones.
  localparam bit ERASED = (FILE == "");

  always_ff @(posedge clk) begin
    if (r_en) begin
      rdata <= ERASED ? '1 : DATA_W'(boot_word(32'(addr)));
    end
  end

endmodule

// File: rtl/boot_ldr_ctr.sv
// Boot loader controller: copies one boot-ROM image into SRAM, sums the copied words
// and holds the CPU in reset until the copy is complete.
//
// state | meaning
// IDLE  | copy finished, CPU released, waiting for a reboot request
// RD    | ROM read of word k issued (or restart in progress)
// WR    | SRAM write of word k offered, held until sram_ready
module boot_ldr_ctr
  import boot_ldr_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          IMG_WORDS = 1024,
  parameter int          N_IMG     = 2,
  parameter int unsigned DST_BASE  = 0,
  parameter int          DEF_IMG   = 0,
  parameter string       ROM_FILE  = "src/boot.hex"
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                cpu_rst,
  output logic                boot,
  input  logic                cpu_valid,
  input  logic                cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                sram_valid,
  input  logic                sram_ready,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (N_IMG > 1) ? $clog2(N_IMG) : 1;
  localparam int K_W    = $clog2(IMG_WORDS);
  localparam int ROM_AW = $clog2(N_IMG * IMG_WORDS);
  localparam logic [K_W-1:0] K_LAST = K_W'(IMG_WORDS - 1);

  state_t            state, state_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic [DATA_W-1:0] checksum, checksum_nxt;
  logic [DATA_W-1:0] hold, word, status;
  logic              held, pend, pend_nxt, restart, reboot_req;
  logic              hs, busy, rom_en;
  logic [SEL_W-1:0]  img_sel, load_img;
  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;
  logic              unused_wdata;

  assign unused_wdata = ^cpu_wdata;

  assign hs   = (state == ST_WR) && sram_ready;
  assign busy = (state != ST_IDLE);
  // The ROM output is captured on the first WR cycle so a long stall cannot disturb it.
  assign word = held ? hold : rom_rdata;

  assign rom_addr   = ROM_AW'(load_img) * ROM_AW'(IMG_WORDS) + ROM_AW'(k);
  assign sram_valid = (state == ST_WR);
  assign sram_addr  = ADDR_W'(DST_BASE) + ADDR_W'(k) * ADDR_W'(STRB_W);
  assign sram_wdata = word;
  assign sram_wstrb = sram_valid ? '1 : '0;

  sp_rom #(
    .DATA_W(DATA_W),
    .ADDR_W(ROM_AW),
    .FILE  (ROM_FILE)
  ) u_rom (
    .clk  (clk),
    .r_en (rom_en),
    .addr (rom_addr),
    .rdata(rom_rdata)
  );

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    checksum_nxt = checksum;
    pend_nxt     = pend;
    restart      = 1'b0;
    rom_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reboot_req) restart = 1'b1;
      end
      ST_RD: begin
        if (reboot_req) begin
          restart = 1'b1;
        end else begin
          rom_en    = 1'b1;
          state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        if (hs) begin
          if (pend || reboot_req) begin
            restart = 1'b1;
          end else begin
            checksum_nxt = checksum + word;
            if (k == K_LAST) begin
              state_nxt = ST_IDLE;
            end else begin
              k_nxt     = k + K_W'(1);
              state_nxt = ST_RD;
            end
          end
        end else if (reboot_req) begin
          pend_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_RD;
    endcase
    if (restart) begin
      state_nxt    = ST_RD;
      k_nxt        = '0;
      checksum_nxt = '0;
      pend_nxt     = 1'b0;
    end
  end

  always_comb begin
    status                       = '0;
    status[BOOT_BIT]             = boot;
    status[BUSY_BIT]             = busy;
    status[IMGSEL_LSB +: SEL_W]  = img_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RD;
      k          <= '0;
      checksum   <= '0;
      pend       <= 1'b0;
      held       <= 1'b0;
      hold       <= '0;
      load_img   <= SEL_W'(DEF_IMG);
      img_sel    <= SEL_W'(DEF_IMG);
      boot       <= 1'b1;
      reboot_req <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      checksum <= checksum_nxt;
      pend     <= pend_nxt;
      held     <= (state == ST_WR) && !hs;
      if (state == ST_WR && !held) hold <= rom_rdata;
      if (restart) load_img <= img_sel;
      cpu_rst    <= (state_nxt != ST_IDLE) || reboot_req;
      cpu_ready  <= cpu_valid;
      reboot_req <= 1'b0;
      if (cpu_valid) begin
        cpu_rdata <= (cpu_addr == REG_CSUM) ? checksum : status;
        if (|cpu_wstrb && cpu_addr == REG_CTRL) begin
          boot       <= cpu_wdata[BOOT_BIT];
          img_sel    <= (N_IMG > 1) ? cpu_wdata[IMGSEL_LSB +: SEL_W] : '0;
          reboot_req <= cpu_wdata[REBOOT_BIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_ldr_ctr.sv
// Directed bench for boot_ldr_ctr with 4-word images and two images in ROM.
module tb_boot_ldr_ctr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rst, boot;
  logic        cpu_valid, cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic        sram_valid, sram_ready;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;

  boot_ldr_ctr #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .IMG_WORDS(4),
    .N_IMG    (2),
    .DST_BASE (0),
    .DEF_IMG  (0),
    .ROM_FILE ("src/boot.hex")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rst   (cpu_rst),
    .boot      (boot),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .sram_valid(sram_valid),
    .sram_ready(sram_ready),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } hs_t;

  typedef struct {
    logic        a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        chk;
    logic [31:0] exp;
  } cpu_vec_t;

  hs_t      hs_q[$];
  hs_t      exp_q[$];
  cpu_vec_t vec[5];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc = 0;
  int       first_hs_cyc = 0;
  int       last_hs_cyc = 0;
  int       fall_cyc = 0;
  logic        rdy;
  logic [31:0] rd;

  localparam logic [31:0] SUM_IMG0 = 32'h48D0_0606;
  localparam logic [31:0] SUM_IMG1 = 32'h48D0_1616;

  // ROM image model: word a = 0x12340000 + 257*a
  function automatic logic [31:0] rom_w(input int a);
    return 32'h1234_0000 + 32'(a) * 32'd257;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n && sram_valid && sram_ready) begin
      hs_q.push_back('{sram_addr, sram_wdata});
      if (hs_q.size() == 1) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_img(input int img);
    for (int i = 0; i < 4; i++) exp_q.push_back('{32'(4 * i), rom_w(img * 4 + i)});
  endfunction

  task automatic check_hs(input string name);
    check({name, " hs count"}, 32'(hs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), hs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s data[%0d]", name, i), hs_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic cpu_acc(input logic a, input logic [31:0] wd, input logic [3:0] ws,
                         output logic r, output logic [31:0] d);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_wstrb = ws;
    @(posedge clk);
    @(negedge clk);
    r = cpu_ready;
    d = cpu_rdata;
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (cpu_rst !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (cpu_rst !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check({name, " copy done"}, 32'(cpu_rst), 32'd0);
    fall_cyc = cyc;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a);
    int n;
    n = 0;
    while (!(sram_valid === 1'b1 && sram_addr === a) && n < 50) begin @(negedge clk); n++; end
    check({name, " reached addr"}, sram_addr, a);
  endtask

  task automatic clear_q();
    hs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec[0] = '{1'b1, 32'h0,         4'h0, 1'b1, SUM_IMG0};
    vec[1] = '{1'b0, 32'h0,         4'h0, 1'b1, 32'h1};
    vec[2] = '{1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vec[3] = '{1'b1, 32'h0,         4'h0, 1'b1, SUM_IMG0};
    vec[4] = '{1'b0, 32'h0,         4'h0, 1'b1, 32'h1};

    rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = 1'b0;
    cpu_wdata = '0; cpu_wstrb = '0; sram_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst boot", 32'(boot), 32'd1);
    check("rst cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst sram_valid", 32'(sram_valid), 32'd0);
    check("rst sram_wstrb", 32'(sram_wstrb), 32'd0);

    // 1: boot copy of default image at full rate
    clear_q();
    rst_n = 1'b1;
    wait_done("t1");
    push_img(0);
    check_hs("t1");
    check("t1 cpu_rst fall cycle", 32'(fall_cyc), 32'(last_hs_cyc));
    check("t1 throughput", 32'(last_hs_cyc - first_hs_cyc), 32'd6);
    cpu_acc(1'b1, 32'h0, 4'h0, rdy, rd);
    check("t1 checksum", rd, SUM_IMG0);
    cpu_acc(1'b0, 32'h0, 4'h0, rdy, rd);
    check("t1 status", rd, 32'h1);

    // 2: stall on word 2 while rebooting image 0
    clear_q();
    cpu_acc(1'b0, 32'h3, 4'hF, rdy, rd);
    wait_addr("t2", 32'd8);
    sram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t2 stall valid %0d", i), 32'(sram_valid), 32'd1);
      check($sformatf("t2 stall addr %0d", i), sram_addr, 32'd8);
      check($sformatf("t2 stall data %0d", i), sram_wdata, rom_w(2));
      check($sformatf("t2 stall wstrb %0d", i), 32'(sram_wstrb), 32'hF);
    end
    sram_ready = 1'b1;
    wait_done("t2");
    push_img(0);
    check_hs("t2");

    // 3: reboot into image 1, boot flag cleared
    clear_q();
    cpu_acc(1'b0, 32'h6, 4'hF, rdy, rd);
    check("t3 ack", 32'(rdy), 32'd1);
    @(negedge clk);
    check("t3 cpu_rst rise", 32'(cpu_rst), 32'd1);
    wait_done("t3");
    push_img(1);
    check_hs("t3");
    cpu_acc(1'b0, 32'h0, 4'h0, rdy, rd);
    check("t3 status", rd, 32'h4);
    cpu_acc(1'b1, 32'h0, 4'h0, rdy, rd);
    check("t3 checksum", rd, SUM_IMG1);

    // 4: reboot request while a write is stalled
    clear_q();
    cpu_acc(1'b0, 32'h6, 4'hF, rdy, rd);
    wait_addr("t4", 32'd4);
    sram_ready = 1'b0;
    cpu_acc(1'b0, 32'h2, 4'hF, rdy, rd);
    repeat (2) @(negedge clk);
    check("t4 held valid", 32'(sram_valid), 32'd1);
    check("t4 held addr", sram_addr, 32'd4);
    check("t4 held data", sram_wdata, rom_w(5));
    sram_ready = 1'b1;
    wait_done("t4");
    exp_q.push_back('{32'd0, rom_w(4)});
    exp_q.push_back('{32'd4, rom_w(5)});
    push_img(0);
    check_hs("t4");
    cpu_acc(1'b1, 32'h0, 4'h0, rdy, rd);
    check("t4 checksum", rd, SUM_IMG0);

    // 5: reset in the middle of an image-1 copy
    cpu_acc(1'b0, 32'h6, 4'hF, rdy, rd);
    wait_addr("t5", 32'd8);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5 cpu_rst", 32'(cpu_rst), 32'd1);
    check("t5 boot", 32'(boot), 32'd1);
    check("t5 cpu_ready", 32'(cpu_ready), 32'd0);
    check("t5 sram_valid", 32'(sram_valid), 32'd0);
    check("t5 sram_wstrb", 32'(sram_wstrb), 32'd0);
    clear_q();
    rst_n = 1'b1;
    wait_done("t5");
    push_img(0);
    check_hs("t5");

    // 6: register accesses in IDLE, including an ignored checksum write
    for (int i = 0; i < 5; i++) begin
      cpu_acc(vec[i].a, vec[i].wd, vec[i].ws, rdy, rd);
      check($sformatf("t6 ready %0d", i), 32'(rdy), 32'd1);
      if (vec[i].chk) check($sformatf("t6 rdata %0d", i), rd, vec[i].exp);
    end
    check("t6 cpu_rst", 32'(cpu_rst), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
